adc_level_mon: RTL and testbench

- Parametrised ADC health monitor in the adc_clk domain, for use in receiver top levels.
- Detects ADC overflow over fixed windows of 2^WIN_BITS samples and applies a hysteresis overload state machine.
- Runs NLEVELS independent magnitude-threshold counters and a per-window peak-magnitude tracker.
- Configuration arrives as strobes already synchronised into adc_clk; outputs are synchronised to cpu_clk by the instantiating level.

---
 rtl/adc_level_mon_if.sv | 9 +
 rtl/adc_level_mon.sv | 136 +++++++++++++
 tb/tb_adc_level_mon.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/adc_level_mon_if.sv
// adc_level_mon_if: configuration write and clear strobes into adc_level_mon (adc_clk domain)
interface adc_level_mon_if;
  logic        cfg_wr;
  logic [2:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        clr;
  modport master (output cfg_wr, cfg_sel, cfg_data, clr);
  modport slave (input cfg_wr, cfg_sel, cfg_data, clr);
endinterface

// File: rtl/adc_level_mon.sv
// adc_level_mon: windowed ADC overflow/overload monitor with threshold counters and peak tracker.
// Define ADC_PEAK_DECAY_EN for peak-hold with exponential decay (shift register at cfg_sel 7).
module adc_level_mon #(
  parameter int ADC_BITS = 14,
  parameter int WIN_BITS = 16,
  parameter int NLEVELS = 2,
  parameter int CNT_BITS = 32,
  parameter int HOLD_WIN = 4
) (
  input  logic                        adc_clk,
  input  logic                        reset_n,
  input  logic [ADC_BITS-1:0]         adc_data,
  input  logic                        adc_ovfl,
  adc_level_mon_if.slave              cfg,
  output logic                        ovfl_pulse,
  output logic                        ovld,
  output logic                        win_done,
  output logic [ADC_BITS-2:0]         peak_mag,
  output logic [NLEVELS*CNT_BITS-1:0] lvl_count
);
  localparam int MB = ADC_BITS - 1;
  typedef enum logic [1:0] {IDLE, OVLD, HOLD} state_t;
  state_t state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [ADC_BITS-1:0] neg;
  logic [MB-1:0] mag_in, mag_r, peak_acc, win_peak, peak_nxt;
  logic [WIN_BITS-1:0] win_ctr, ovfl_cnt, ovfl_sum, mask;
  logic ovfl_r, valid_r, close, hit_win, wr, leave, unused_ok;
  assign unused_ok = ^cfg.cfg_data;
  assign wr = cfg.cfg_wr && !cfg.clr;
  // only the most negative code has no positive twin; it saturates
  assign neg = -adc_data;
  assign mag_in = !adc_data[ADC_BITS-1] ? adc_data[MB-1:0] : neg[ADC_BITS-1] ? '1 : neg[MB-1:0];
  always_ff @(posedge adc_clk or negedge reset_n)
    if (!reset_n) begin
      mag_r <= '0;
      ovfl_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      mag_r <= mag_in;
      ovfl_r <= adc_ovfl;
      valid_r <= !cfg.clr;
    end
  assign close = valid_r && !cfg.clr && &win_ctr;
  assign ovfl_sum = ovfl_cnt + WIN_BITS'(ovfl_r);
  assign hit_win = |(ovfl_sum & mask);
  assign win_peak = mag_r > peak_acc ? mag_r : peak_acc;
`ifdef ADC_PEAK_DECAY_EN
  logic [2:0] decay_shift;
  logic [MB-1:0] decayed;
  always_ff @(posedge adc_clk or negedge reset_n)
    if (!reset_n) decay_shift <= 3'd2;
    else if (wr && cfg.cfg_sel == 3'd7) decay_shift <= cfg.cfg_data[2:0];
  assign decayed = peak_mag - (peak_mag >> decay_shift);
  assign peak_nxt = win_peak > decayed ? win_peak : decayed;
`else
  assign peak_nxt = win_peak;
`endif
  always_ff @(posedge adc_clk or negedge reset_n)
    if (!reset_n) mask <= '1;
    else if (wr && cfg.cfg_sel == 3'd0) mask <= cfg.cfg_data[WIN_BITS-1:0];
  always_ff @(posedge adc_clk or negedge reset_n)
    if (!reset_n) begin
      win_ctr <= '0;
      ovfl_cnt <= '0;
      peak_acc <= '0;
      peak_mag <= '0;
      win_done <= 1'b0;
      ovfl_pulse <= 1'b0;
    end else if (cfg.clr) begin
      win_ctr <= '0;
      ovfl_cnt <= '0;
      peak_acc <= '0;
      peak_mag <= '0;
      win_done <= 1'b0;
      ovfl_pulse <= 1'b0;
    end else begin
      win_done <= close;
      ovfl_pulse <= close && hit_win;
      if (close) peak_mag <= peak_nxt;
      if (valid_r) begin
        win_ctr <= win_ctr + 1'b1;
        ovfl_cnt <= close ? '0 : ovfl_sum;
        peak_acc <= close ? '0 : win_peak;
      end
    end
  for (genvar k = 0; k < NLEVELS; k++) begin : g_lvl
    logic [ADC_BITS-1:0] thr;
    logic [CNT_BITS-1:0] cnt;
    logic sel, hit;
    assign sel = wr && cfg.cfg_sel == 3'(k + 1);
    // threshold MSB picks overflow counting instead of magnitude compare
    assign hit = thr[MB] ? ovfl_r : mag_r >= thr[MB-1:0];
    always_ff @(posedge adc_clk or negedge reset_n)
      if (!reset_n) begin
        thr <= '1;
        cnt <= '0;
      end else if (cfg.clr) cnt <= '0;
      else if (sel) begin
        thr <= cfg.cfg_data[ADC_BITS-1:0];
        cnt <= '0;
      end else if (valid_r && hit && !(&cnt)) cnt <= cnt + 1'b1;
    assign lvl_count[k*CNT_BITS +: CNT_BITS] = cnt;
  end
  always_ff @(posedge adc_clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  // hold_cnt counts clean windows seen in HOLD, including the one that entered it
  assign leave = 5'(hold_cnt) + 5'd1 >= 5'(HOLD_WIN);
  always_comb begin
    state_nxt = state;
    hold_nxt = hold_cnt;
    if (cfg.clr) begin
      state_nxt = IDLE;
      hold_nxt = '0;
    end else if (close)
      case (state)
        IDLE: state_nxt = hit_win ? OVLD : IDLE;
        OVLD: begin
          state_nxt = hit_win ? OVLD : HOLD_WIN == 1 ? IDLE : HOLD;
          hold_nxt = 4'd1;
        end
        HOLD: begin
          state_nxt = hit_win ? OVLD : leave ? IDLE : HOLD;
          hold_nxt = hold_cnt + 4'd1;
        end
        default: state_nxt = IDLE;
      endcase
  end
  always_comb ovld = state != IDLE;
endmodule

// File: tb/tb_adc_level_mon.sv
// tb_adc_level_mon: directed vector bench for adc_level_mon (14-bit ADC, 16-sample windows, HOLD_WIN 2)
module tb_adc_level_mon;
  logic adc_clk = 1'b0, reset_n = 1'b0, adc_ovfl = 1'b0;
  logic [13:0] adc_data = '0;
  logic ovfl_pulse, ovld, win_done, n_ovfl_pulse, n_ovld, n_win_done;
  logic [12:0] peak_mag, n_peak_mag;
  logic [63:0] lvl_count;
  logic [7:0] n_lvl_count;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [13:0] data;
    int          novf;
    logic [3:0]  mask;
    logic [13:0] thr0;
    logic [12:0] peak;
    logic        pulse;
    int          cnt0;
  } vec_t;
  vec_t tbl [9];
  adc_level_mon_if cfg_bus ();
  always #5 adc_clk = ~adc_clk;
  adc_level_mon #(.ADC_BITS(14), .WIN_BITS(4), .NLEVELS(2), .CNT_BITS(32), .HOLD_WIN(2)) u_dut (
    .adc_clk(adc_clk), .reset_n(reset_n), .adc_data(adc_data), .adc_ovfl(adc_ovfl), .cfg(cfg_bus),
    .ovfl_pulse(ovfl_pulse), .ovld(ovld), .win_done(win_done), .peak_mag(peak_mag), .lvl_count(lvl_count));
  adc_level_mon #(.ADC_BITS(14), .WIN_BITS(4), .NLEVELS(2), .CNT_BITS(4), .HOLD_WIN(2)) u_nar (
    .adc_clk(adc_clk), .reset_n(reset_n), .adc_data(adc_data), .adc_ovfl(adc_ovfl), .cfg(cfg_bus),
    .ovfl_pulse(n_ovfl_pulse), .ovld(n_ovld), .win_done(n_win_done), .peak_mag(n_peak_mag), .lvl_count(n_lvl_count));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge adc_clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] sel, input logic [31:0] d);
    cfg_bus.cfg_wr = 1'b1;
    cfg_bus.cfg_sel = sel;
    cfg_bus.cfg_data = d;
    tick;
    cfg_bus.cfg_wr = 1'b0;
  endtask
  task automatic do_clr;
    cfg_bus.clr = 1'b1;
    tick;
    cfg_bus.clr = 1'b0;
  endtask
  // bit w of hits marks an overflow in window w; bit w of expo is ovld after that window closes
  task automatic fsm_run(input logic [7:0] hits, input int nwin, input logic [7:0] expo);
    int nclose = 0;
    wr(3'd0, 32'hF);
    adc_data = '0;
    do_clr;
    for (int w = 0; w <= nwin; w++)
      for (int s = 0; s < (w == nwin ? 1 : 16); s++) begin
        adc_ovfl = w < nwin && hits[w] && s == 0;
        tick;
        if (win_done) begin
          chk($sformatf("ovld_close%0d", nclose + 1), ovld, expo[nclose]);
          nclose++;
        end
      end
    chk("fsm_closes", nclose, nwin);
  endtask
  initial begin
    int first;
    cfg_bus.cfg_wr = 1'b0;
    cfg_bus.cfg_sel = '0;
    cfg_bus.cfg_data = '0;
    cfg_bus.clr = 1'b0;
    repeat (3) tick;
    chk("rst_ovld", ovld, 0);
    chk("rst_win_done", win_done, 0);
    chk("rst_ovfl_pulse", ovfl_pulse, 0);
    chk("rst_peak", peak_mag, 0);
    chk("rst_cnt", lvl_count, 0);
    reset_n = 1'b1;
    tick;
    wr(3'd1, 32'h0800);
    do_clr;
    for (int j = 1; j <= 41; j++) begin
      adc_data = j <= 40 ? 14'h1000 : 14'h0000;
      tick;
      chk($sformatf("t1_win_done_%0d", j), win_done, j == 17 || j == 33);
      chk($sformatf("t1_ovfl_pulse_%0d", j), ovfl_pulse, 0);
      if (j == 17) chk("t1_peak", peak_mag, 4096);
      if (j == 40) chk("t1_cnt39", lvl_count[31:0], 39);
    end
    chk("t1_cnt40", lvl_count[31:0], 40);
    tbl[0] = '{14'h1000, 0, 4'hF, 14'h0800, 13'd4096, 1'b0, 16};
    tbl[1] = '{14'h2000, 0, 4'hF, 14'h1FFF, 13'd8191, 1'b0, 16};
    tbl[2] = '{14'h3001, 0, 4'hF, 14'h0FFF, 13'd4095, 1'b0, 16};
    tbl[3] = '{14'h3001, 0, 4'hF, 14'h1000, 13'd4095, 1'b0, 0};
    tbl[4] = '{14'h0005, 3, 4'h4, 14'h2000, 13'd5,    1'b0, 3};
    tbl[5] = '{14'h0005, 3, 4'h2, 14'h2000, 13'd5,    1'b1, 3};
    tbl[6] = '{14'h1FFF, 4, 4'h4, 14'h0000, 13'd8191, 1'b1, 16};
    tbl[7] = '{14'h3FFF, 8, 4'h8, 14'h0002, 13'd1,    1'b1, 0};
    tbl[8] = '{14'h0000, 1, 4'h8, 14'h3FFF, 13'd0,    1'b0, 1};
    for (int i = 0; i < 9; i++) begin
      wr(3'd0, {28'h0, tbl[i].mask});
      wr(3'd1, {18'h0, tbl[i].thr0});
      do_clr;
      for (int s = 1; s <= 16; s++) begin
        adc_data = tbl[i].data;
        adc_ovfl = s <= tbl[i].novf;
        tick;
      end
      chk($sformatf("v%0d_early_done", i), win_done, 0);
      adc_data = '0;
      adc_ovfl = 1'b0;
      tick;
      chk($sformatf("v%0d_win_done", i), win_done, 1);
      chk($sformatf("v%0d_peak", i), peak_mag, tbl[i].peak);
      chk($sformatf("v%0d_pulse", i), ovfl_pulse, tbl[i].pulse);
      chk($sformatf("v%0d_ovld", i), ovld, tbl[i].pulse);
      chk($sformatf("v%0d_cnt0", i), lvl_count[31:0], tbl[i].cnt0);
      chk($sformatf("v%0d_ncnt0", i), n_lvl_count[3:0], tbl[i].cnt0 > 15 ? 15 : tbl[i].cnt0);
    end
    fsm_run(8'b0000_0011, 4, 8'b0000_0111);
    fsm_run(8'b0000_0111, 5, 8'b0000_1111);
    fsm_run(8'b0000_0101, 5, 8'b0000_1111);
    fsm_run(8'b0000_0001, 1, 8'b0000_0001);
    do_clr;
    chk("clr_ovld", ovld, 0);
    wr(3'd0, 32'hF);
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h0);
    adc_data = 14'h0100;
    do_clr;
    repeat (20) tick;
    chk("t5_cnt0", lvl_count[31:0], 19);
    chk("t5_cnt1", lvl_count[63:32], 19);
    chk("t5_nar_cnt1_sat", n_lvl_count[7:4], 15);
    chk("t5_nar_cnt0_sat", n_lvl_count[3:0], 15);
    wr(3'd2, 32'h0);
    chk("t5_wr_cnt1", lvl_count[63:32], 0);
    chk("t5_wr_cnt0", lvl_count[31:0], 20);
    chk("t5_wr_nar_cnt1", n_lvl_count[7:4], 0);
    tick;
    chk("t5_after_wr_cnt1", lvl_count[63:32], 1);
    chk("t5_pre_clr_peak", peak_mag, 256);
    cfg_bus.clr = 1'b1;
    cfg_bus.cfg_wr = 1'b1;
    cfg_bus.cfg_sel = 3'd1;
    cfg_bus.cfg_data = 32'h1FFF;
    tick;
    cfg_bus.clr = 1'b0;
    cfg_bus.cfg_wr = 1'b0;
    chk("t5_clr_cnt", lvl_count, 0);
    chk("t5_clr_nar_cnt", n_lvl_count, 0);
    chk("t5_clr_peak", peak_mag, 0);
    tick;
    chk("t5_clr_invalid", lvl_count[31:0], 0);
    adc_ovfl = 1'b1;
    tick;
    chk("t5_thr_kept", lvl_count[31:0], 1);
    chk("t5_cnt1_resume", lvl_count[63:32], 1);
    repeat (20) tick;
    chk("t6_pre_ovld", ovld, 1);
    chk("t6_pre_peak", peak_mag, 256);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async_ovld", ovld, 0);
    chk("t6_async_peak", peak_mag, 0);
    chk("t6_async_cnt", lvl_count, 0);
    chk("t6_async_done", win_done, 0);
    chk("t6_async_pulse", ovfl_pulse, 0);
    @(posedge adc_clk);
    #4;
    reset_n = 1'b1;
    first = 0;
    for (int e = 1; e <= 40 && first == 0; e++) begin
      tick;
      if (win_done) first = e;
    end
    chk("t6_first_done", first, 17);
    chk("t6_default_thr", lvl_count[31:0], 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end
endmodule
